// File: rtl/ysyx_23060208_rd_xbar_pkg.sv
// Shared constants and types for the two-master AXI-Lite read crossbar:
// default address map, response codes and FSM state encoding.
package ysyx_23060208_rd_xbar_pkg;

  localparam logic [31:0] SRAM_BASE_DEF  = 32'h8000_0000;
  localparam logic [31:0] SRAM_SIZE_DEF  = 32'h0800_0000;
  localparam logic [31:0] CLINT_BASE_DEF = 32'ha000_0048;
  localparam logic [31:0] CLINT_SIZE_DEF = 32'h0000_0008;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAr   = 2'd1,
    StR    = 2'd2,
    StErr  = 2'd3
  } state_e;

endpackage

// File: rtl/ysyx_23060208_rr_arb2.sv
// Two-way round-robin arbiter. The last-grant register remembers which master
// finished most recently so that a tie goes to the other one.
module ysyx_23060208_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic       upd_id_i,
  output logic [1:0] gnt_o
);

  logic last_q;

  // Reset to m1 so that m0 wins the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else if (upd_i) begin
      last_q <= upd_id_i;
    end
  end

  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/ysyx_23060208_rd_xbar.sv
// Two-master, two-slave AXI-Lite read crossbar (SRAM + CLINT) with local DECERR,
// one outstanding transaction and round-robin arbitration.
module ysyx_23060208_rd_xbar
  import ysyx_23060208_rd_xbar_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] SRAM_BASE  = SRAM_BASE_DEF,
  parameter logic [DATA_WIDTH-1:0] SRAM_SIZE  = SRAM_SIZE_DEF,
  parameter logic [DATA_WIDTH-1:0] CLINT_BASE = CLINT_BASE_DEF,
  parameter logic [DATA_WIDTH-1:0] CLINT_SIZE = CLINT_SIZE_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic [DATA_WIDTH-1:0] m0_araddr_i,
  input  logic                  m0_arvalid_i,
  output logic                  m0_arready_o,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  output logic [1:0]            m0_rresp_o,
  output logic                  m0_rvalid_o,
  input  logic                  m0_rready_i,

  input  logic [DATA_WIDTH-1:0] m1_araddr_i,
  input  logic                  m1_arvalid_i,
  output logic                  m1_arready_o,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic [1:0]            m1_rresp_o,
  output logic                  m1_rvalid_o,
  input  logic                  m1_rready_i,

  output logic [DATA_WIDTH-1:0] sram_araddr_o,
  output logic                  sram_arvalid_o,
  input  logic                  sram_arready_i,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i,
  input  logic [1:0]            sram_rresp_i,
  input  logic                  sram_rvalid_i,
  output logic                  sram_rready_o,

  output logic [DATA_WIDTH-1:0] clint_araddr_o,
  output logic                  clint_arvalid_o,
  input  logic                  clint_arready_i,
  input  logic [DATA_WIDTH-1:0] clint_rdata_i,
  input  logic [1:0]            clint_rresp_i,
  input  logic                  clint_rvalid_i,
  output logic                  clint_rready_o
);

  state_e                  state_q;
  logic                    gnt_q;        // 0: m0, 1: m1
  logic                    sel_clint_q;
  logic [DATA_WIDTH-1:0]   addr_q;

  logic [1:0]              gnt;
  logic                    accept;
  logic                    done;
  logic [DATA_WIDTH-1:0]   req_addr;
  logic                    hit_sram;
  logic                    hit_clint;

  logic                    slv_arready;
  logic                    slv_rvalid;
  logic [DATA_WIDTH-1:0]   slv_rdata;
  logic [1:0]              slv_rresp;
  logic                    mst_rready;

  logic                    rsp_valid;
  logic [DATA_WIDTH-1:0]   rsp_data;
  logic [1:0]              rsp_resp;

  // Subtract-then-compare keeps the window test free of overflow at the top of memory.
  function automatic logic in_window(input logic [DATA_WIDTH-1:0] addr,
                                     input logic [DATA_WIDTH-1:0] base,
                                     input logic [DATA_WIDTH-1:0] size);
    logic [DATA_WIDTH-1:0] off;
    off = addr - base;
    return (addr >= base) && (off < size);
  endfunction

  ysyx_23060208_rr_arb2 u_arb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    ({m1_arvalid_i, m0_arvalid_i}),
    .upd_i    (done),
    .upd_id_i (gnt_q),
    .gnt_o    (gnt)
  );

  assign accept    = (state_q == StIdle) && (gnt != 2'b00);
  assign req_addr  = gnt[1] ? m1_araddr_i : m0_araddr_i;
  assign hit_sram  = in_window(req_addr, SRAM_BASE, SRAM_SIZE);
  assign hit_clint = in_window(req_addr, CLINT_BASE, CLINT_SIZE);

  assign slv_arready = sel_clint_q ? clint_arready_i : sram_arready_i;
  assign slv_rvalid  = sel_clint_q ? clint_rvalid_i  : sram_rvalid_i;
  assign slv_rdata   = sel_clint_q ? clint_rdata_i   : sram_rdata_i;
  assign slv_rresp   = sel_clint_q ? clint_rresp_i   : sram_rresp_i;
  assign mst_rready  = gnt_q ? m1_rready_i : m0_rready_i;

  assign done = ((state_q == StR) && slv_rvalid && mst_rready) ||
                ((state_q == StErr) && mst_rready);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      gnt_q       <= 1'b0;
      sel_clint_q <= 1'b0;
      addr_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            addr_q      <= req_addr;
            gnt_q       <= gnt[1];
            sel_clint_q <= hit_clint;
            state_q     <= (hit_clint || hit_sram) ? StAr : StErr;
          end
        end
        StAr: begin
          if (slv_arready) state_q <= StR;
        end
        StR: begin
          if (slv_rvalid && mst_rready) state_q <= StIdle;
        end
        StErr: begin
          if (mst_rready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    rsp_valid = 1'b0;
    rsp_data  = '0;
    rsp_resp  = RESP_OKAY;
    unique case (state_q)
      StR: begin
        rsp_valid = slv_rvalid;
        rsp_data  = slv_rdata;
        rsp_resp  = slv_rresp;
      end
      StErr: begin
        rsp_valid = 1'b1;
        rsp_resp  = RESP_DECERR;
      end
      default: ;
    endcase
  end

  assign m0_arready_o = (state_q == StIdle) && gnt[0];
  assign m1_arready_o = (state_q == StIdle) && gnt[1];

  assign m0_rvalid_o = !gnt_q ? rsp_valid : 1'b0;
  assign m0_rdata_o  = !gnt_q ? rsp_data  : '0;
  assign m0_rresp_o  = !gnt_q ? rsp_resp  : RESP_OKAY;
  assign m1_rvalid_o = gnt_q  ? rsp_valid : 1'b0;
  assign m1_rdata_o  = gnt_q  ? rsp_data  : '0;
  assign m1_rresp_o  = gnt_q  ? rsp_resp  : RESP_OKAY;

  assign sram_araddr_o   = addr_q;
  assign clint_araddr_o  = addr_q;
  assign sram_arvalid_o  = (state_q == StAr) && !sel_clint_q;
  assign clint_arvalid_o = (state_q == StAr) && sel_clint_q;
  assign sram_rready_o   = (state_q == StR) && !sel_clint_q && mst_rready;
  assign clint_rready_o  = (state_q == StR) && sel_clint_q && mst_rready;

endmodule

// File: tb/tb_ysyx_23060208_rd_xbar.sv
// Self-checking bench for the read crossbar: directed vector table, hand-written
// corner sequences and randomized traffic against an address-map reference model.
module tb_ysyx_23060208_rd_xbar;

  logic clk;
  logic rst;

  logic [1:0]        m_arvalid;
  logic [1:0][31:0]  m_araddr;
  logic [1:0]        m_rready;
  logic [1:0]        m_arready;
  logic [1:0]        m_rvalid;
  logic [1:0][31:0]  m_rdata;
  logic [1:0][1:0]   m_rresp;

  // Slave index 0 = SRAM, 1 = CLINT.
  logic [1:0][31:0]  s_araddr;
  logic [1:0]        s_arvalid;
  logic [1:0]        s_arready;
  logic [1:0][31:0]  s_rdata;
  logic [1:0][1:0]   s_rresp;
  logic [1:0]        s_rvalid;
  logic [1:0]        s_rready;

  logic [1:0]        s_ar_en;
  int                s_lat [2];
  logic [1:0]        s_pend;
  logic [1:0][31:0]  s_addr_l;
  int                s_cnt [2];

  ysyx_23060208_rd_xbar dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .m0_araddr_i     (m_araddr[0]),
    .m0_arvalid_i    (m_arvalid[0]),
    .m0_arready_o    (m_arready[0]),
    .m0_rdata_o      (m_rdata[0]),
    .m0_rresp_o      (m_rresp[0]),
    .m0_rvalid_o     (m_rvalid[0]),
    .m0_rready_i     (m_rready[0]),
    .m1_araddr_i     (m_araddr[1]),
    .m1_arvalid_i    (m_arvalid[1]),
    .m1_arready_o    (m_arready[1]),
    .m1_rdata_o      (m_rdata[1]),
    .m1_rresp_o      (m_rresp[1]),
    .m1_rvalid_o     (m_rvalid[1]),
    .m1_rready_i     (m_rready[1]),
    .sram_araddr_o   (s_araddr[0]),
    .sram_arvalid_o  (s_arvalid[0]),
    .sram_arready_i  (s_arready[0]),
    .sram_rdata_i    (s_rdata[0]),
    .sram_rresp_i    (s_rresp[0]),
    .sram_rvalid_i   (s_rvalid[0]),
    .sram_rready_o   (s_rready[0]),
    .clint_araddr_o  (s_araddr[1]),
    .clint_arvalid_o (s_arvalid[1]),
    .clint_arready_i (s_arready[1]),
    .clint_rdata_i   (s_rdata[1]),
    .clint_rresp_i   (s_rresp[1]),
    .clint_rvalid_i  (s_rvalid[1]),
    .clint_rready_o  (s_rready[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model of slave contents and address map ----------------
  function automatic logic [31:0] slv_data(input int s, input logic [31:0] a);
    if (s == 0) return a ^ 32'h5ead_beff;
    return a[2] ? 32'h0000_0007 : 32'h0000_0001;
  endfunction

  function automatic logic [1:0] slv_resp(input int s, input logic [31:0] a);
    if (s == 0 && a[2]) return 2'b10;
    return 2'b00;
  endfunction

  function automatic int ref_target(input logic [31:0] a);
    longint unsigned x;
    x = {32'h0, a};
    if (x >= 64'ha000_0048 && x < 64'ha000_0050) return 1;
    if (x >= 64'h8000_0000 && x < 64'h8800_0000) return 0;
    return 2;
  endfunction

  // ---------------- behavioural slaves ----------------
  always @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (rst) begin
        s_pend[s]   <= 1'b0;
        s_rvalid[s] <= 1'b0;
        s_cnt[s]    <= 0;
        s_addr_l[s] <= '0;
      end else if (s_rvalid[s]) begin
        if (s_rready[s]) begin
          s_rvalid[s] <= 1'b0;
          s_pend[s]   <= 1'b0;
        end
      end else if (s_pend[s]) begin
        if (s_cnt[s] == 0) s_rvalid[s] <= 1'b1;
        else               s_cnt[s]    <= s_cnt[s] - 1;
      end else if (s_arvalid[s] && s_arready[s]) begin
        s_pend[s]   <= 1'b1;
        s_addr_l[s] <= s_araddr[s];
        s_cnt[s]    <= s_lat[s];
        s_rvalid[s] <= (s_lat[s] == 0);
      end
    end
  end

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      s_arready[s] = s_ar_en[s] && !s_pend[s];
      s_rdata[s]   = s_rvalid[s] ? slv_data(s, s_addr_l[s]) : 32'hbad0_0bad;
      s_rresp[s]   = s_rvalid[s] ? slv_resp(s, s_addr_l[s]) : 2'b01;
    end
  end

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t        exp_q0 [$];
  exp_t        exp_q1 [$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          outstanding = 0;
  int          last_acc = 1;
  int          cur_m = 0;
  int          cur_tgt = 0;
  logic [31:0] cur_addr = '0;
  int          acc_cnt [2] = '{0, 0};
  int          rsp_cnt [2] = '{0, 0};
  int          acc_cyc [2] = '{0, 0};
  int          rsp_cyc [2] = '{0, 0};
  logic [1:0][31:0] last_data;
  logic [1:0][1:0]  last_resp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    int   t;
    if (rst) begin
      exp_q0.delete();
      exp_q1.delete();
      outstanding = 0;
      last_acc    = 1;
      return;
    end
    for (int m = 0; m < 2; m++) begin
      if (m_arready[m]) begin
        chk("arready_busy", outstanding, 0);
        chk("arready_noreq", m_arvalid[m], 1);
        chk("arready_both", m_arready[1-m], 0);
        if (m_arvalid[m]) begin
          if (m_arvalid[1-m]) chk("rr_tie", m, 1 - last_acc);
          t = ref_target(m_araddr[m]);
          e.data = (t == 2) ? 32'h0 : slv_data(t, m_araddr[m]);
          e.resp = (t == 2) ? 2'b11 : slv_resp(t, m_araddr[m]);
          if (m == 0) exp_q0.push_back(e);
          else        exp_q1.push_back(e);
          cur_m = m; cur_tgt = t; cur_addr = m_araddr[m];
          outstanding = 1; last_acc = m;
          acc_cnt[m]++; acc_cyc[m] = cyc;
        end
      end
    end
    for (int s = 0; s < 2; s++) begin
      if (s_arvalid[s]) begin
        chk("slv_ar_busy", outstanding, 1);
        chk("slv_ar_sel", s, cur_tgt);
        chk("slv_ar_addr", s_araddr[s], cur_addr);
      end
      if (s_rready[s]) begin
        chk("slv_rready_sel", s, cur_tgt);
        chk("slv_rready_fwd", m_rready[cur_m], 1);
      end
    end
    for (int m = 0; m < 2; m++) begin
      if (!(outstanding == 1 && m == cur_m)) begin
        chk("idle_rsp_zero", {m_rvalid[m], m_rresp[m], m_rdata[m]}, 0);
      end else if (m_rvalid[m] && m_rready[m]) begin
        if ((m == 0 && exp_q0.size() == 0) || (m == 1 && exp_q1.size() == 0)) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          e = (m == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          chk("rsp_data", m_rdata[m], e.data);
          chk("rsp_resp", m_rresp[m], e.resp);
        end
        outstanding = 0;
        rsp_cnt[m]++; rsp_cyc[m] = cyc;
        last_data[m] = m_rdata[m];
        last_resp[m] = m_rresp[m];
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_acc(input int m);
    int c0;
    c0 = acc_cnt[m];
    for (int i = 0; i < 40 && acc_cnt[m] == c0; i++) tick();
    chk("acc_timeout", acc_cnt[m] - c0, 1);
  endtask

  task automatic wait_rsp(input int m);
    int c0;
    c0 = rsp_cnt[m];
    for (int i = 0; i < 40 && rsp_cnt[m] == c0; i++) tick();
    chk("rsp_timeout", rsp_cnt[m] - c0, 1);
  endtask

  task automatic do_read(input int m, input logic [31:0] a, output logic [31:0] d,
                         output logic [1:0] r, output int lat);
    m_araddr[m]  = a;
    m_arvalid[m] = 1'b1;
    m_rready[m]  = 1'b1;
    wait_acc(m);
    m_arvalid[m] = 1'b0;
    wait_rsp(m);
    d   = last_data[m];
    r   = last_resp[m];
    lat = rsp_cyc[m] - acc_cyc[m];
  endtask

  task automatic chk_reset_outs(input string name);
    chk({name, "_m_rvalid"}, m_rvalid, 0);
    chk({name, "_m_rdata"}, {m_rdata[1], m_rdata[0]}, 0);
    chk({name, "_m_rresp"}, {m_rresp[1], m_rresp[0]}, 0);
    chk({name, "_s_arvalid"}, s_arvalid, 0);
    chk({name, "_s_rready"}, s_rready, 0);
    chk({name, "_s_araddr"}, {s_araddr[1], s_araddr[0]}, 0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] b [6];
    b = '{32'h8000_0000, 32'h87ff_fffc, 32'h8800_0000, 32'ha000_0044,
          32'ha000_0050, 32'hffff_fffc};
    case ($urandom_range(0, 5))
      0, 1:    return 32'h8000_0000 + ($urandom_range(0, 32'h01ff_ffff) << 2);
      2:       return ($urandom_range(0, 1) != 0) ? 32'ha000_0048 : 32'ha000_004c;
      3:       return b[$urandom_range(0, 5)];
      default: return $urandom();
    endcase
  endfunction

  typedef struct {
    int          m;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;
    int          lat;
  } vec_t;

  initial begin
    vec_t        vecs [11];
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    int          c0;
    int          c1;
    int          remaining [2];
    int          gap [2];
    int          prev_acc [2];
    int          rsp_base;

    vecs[0]  = '{0, 32'h8000_0010, 32'hdead_beef, 2'b00, 2};
    vecs[1]  = '{1, 32'h8000_0000, 32'hdead_beff, 2'b00, 2};
    vecs[2]  = '{0, 32'h87ff_fffc, 32'hd952_4103, 2'b10, 2};
    vecs[3]  = '{1, 32'ha000_0048, 32'h0000_0001, 2'b00, 2};
    vecs[4]  = '{0, 32'ha000_004c, 32'h0000_0007, 2'b00, 2};
    vecs[5]  = '{1, 32'h1000_0000, 32'h0000_0000, 2'b11, 1};
    vecs[6]  = '{0, 32'h8800_0000, 32'h0000_0000, 2'b11, 1};
    vecs[7]  = '{1, 32'h7fff_fffc, 32'h0000_0000, 2'b11, 1};
    vecs[8]  = '{0, 32'ha000_0044, 32'h0000_0000, 2'b11, 1};
    vecs[9]  = '{1, 32'ha000_0050, 32'h0000_0000, 2'b11, 1};
    vecs[10] = '{0, 32'hffff_fffc, 32'h0000_0000, 2'b11, 1};

    rst       = 1'b1;
    m_arvalid = '0;
    m_araddr  = '0;
    m_rready  = '0;
    s_ar_en   = 2'b11;
    s_lat     = '{0, 0};
    last_data = '0;
    last_resp = '0;
    repeat (3) tick();
    chk_reset_outs("rst");
    rst = 1'b0;
    chk_reset_outs("rst_rel");

    // Tie on the first cycle after reset: m0 first from SRAM, then m1 from CLINT.
    m_araddr[0] = 32'h8000_0000; m_araddr[1] = 32'ha000_0048;
    m_arvalid   = 2'b11;         m_rready    = 2'b11;
    c0 = acc_cnt[0]; c1 = acc_cnt[1];
    tick();
    chk("tie_m0_first", acc_cnt[0] - c0, 1);
    chk("tie_m1_waits", acc_cnt[1] - c1, 0);
    m_arvalid[0] = 1'b0;
    wait_rsp(0);
    chk("tie_m0_data", last_data[0], 32'hdead_beff);
    wait_acc(1);
    m_arvalid[1] = 1'b0;
    wait_rsp(1);
    chk("tie_m1_data", last_data[1], 32'h0000_0001);

    // Vector table, all slaves immediately ready.
    foreach (vecs[i]) begin
      do_read(vecs[i].m, vecs[i].addr, d, r, lat);
      chk("vec_data", d, vecs[i].data);
      chk("vec_resp", r, vecs[i].resp);
      chk("vec_lat", lat, vecs[i].lat);
    end

    // CLINT withholds arready: request must be held stable.
    s_ar_en[1]  = 1'b0;
    m_araddr[1] = 32'ha000_004c; m_arvalid[1] = 1'b1; m_rready[1] = 1'b1;
    wait_acc(1);
    m_arvalid[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_arvalid", s_arvalid[1], 1);
      chk("stall_araddr", s_araddr[1], 32'ha000_004c);
    end
    s_ar_en[1] = 1'b1;
    wait_rsp(1);
    chk("stall_data", last_data[1], 32'h0000_0007);

    // m0 back-pressures the response while m1 is waiting.
    s_lat[0]    = 1;
    m_araddr[0] = 32'h8000_0010; m_arvalid[0] = 1'b1; m_rready[0] = 1'b0;
    wait_acc(0);
    m_arvalid[0] = 1'b0;
    m_araddr[1]  = 32'h8000_0004; m_arvalid[1] = 1'b1; m_rready[1] = 1'b1;
    for (int i = 0; i < 10 && !m_rvalid[0]; i++) tick();
    chk("hold_rvalid_rise", m_rvalid[0], 1);
    for (int i = 0; i < 3; i++) begin
      chk("hold_s_rready", s_rready[0], 0);
      chk("hold_rvalid", m_rvalid[0], 1);
      chk("hold_rdata", m_rdata[0], 32'hdead_beef);
      chk("hold_m1_arready", m_arready[1], 0);
      tick();
    end
    m_rready[0] = 1'b1;
    wait_rsp(0);
    wait_acc(1);
    m_arvalid[1] = 1'b0;
    wait_rsp(1);
    chk("hold_m1_data", last_data[1], 32'hdead_befb);
    chk("hold_m1_resp", last_resp[1], 2'b10);

    // Reset in R after an m0 completion: the tie afterwards must again go to m0.
    s_lat[0] = 0;
    do_read(0, 32'h8000_0020, d, r, lat);
    s_lat[0]    = 4;
    m_araddr[0] = 32'h8000_0030; m_arvalid[0] = 1'b1; m_rready[0] = 1'b0;
    wait_acc(0);
    m_arvalid[0] = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    chk_reset_outs("midrst");
    rst = 1'b0;
    s_lat[0] = 0;
    m_araddr[0] = 32'h8000_0008; m_araddr[1] = 32'ha000_0048;
    m_arvalid   = 2'b11;         m_rready    = 2'b11;
    c0 = acc_cnt[0]; c1 = acc_cnt[1];
    tick();
    chk("midrst_tie_m0", acc_cnt[0] - c0, 1);
    chk("midrst_tie_m1", acc_cnt[1] - c1, 0);
    m_arvalid[0] = 1'b0;
    wait_rsp(0);
    wait_acc(1);
    m_arvalid[1] = 1'b0;
    wait_rsp(1);

    // Randomized traffic against the scoreboard.
    remaining = '{150, 150};
    gap       = '{0, 0};
    prev_acc  = acc_cnt;
    rsp_base  = rsp_cnt[0] + rsp_cnt[1];
    for (int it = 0; it < 20000 &&
         (remaining[0] > 0 || remaining[1] > 0 || m_arvalid != 0 || outstanding != 0); it++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        if (m_arvalid[m] && acc_cnt[m] != prev_acc[m]) begin
          prev_acc[m]  = acc_cnt[m];
          m_arvalid[m] = 1'b0;
          remaining[m]--;
          gap[m] = $urandom_range(0, 3);
        end else if (!m_arvalid[m]) begin
          if (gap[m] > 0) begin
            gap[m]--;
          end else if (remaining[m] > 0) begin
            m_araddr[m]  = rand_addr();
            m_arvalid[m] = 1'b1;
          end
        end
        m_rready[m] = ($urandom_range(0, 3) != 0);
      end
      s_ar_en  = {$urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0};
      s_lat[0] = $urandom_range(0, 3);
      s_lat[1] = $urandom_range(0, 3);
    end
    chk("rnd_drained", remaining[0] + remaining[1] + outstanding, 0);
    chk("rnd_rsp_count", rsp_cnt[0] + rsp_cnt[1] - rsp_base, 300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
